// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, models fixed multi-cycle latency
// and reports busy to the stall unit. Results land in HI/LO when the count expires.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Op1,
    input  logic [31:0] Op2,
    input  logic [3:0]  MDUOp,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDUResult
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [3:0]         r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_phi;
    logic [31:0]        r_plo;
    logic               r_pwe;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_div0;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic [31:0]        w_divisor;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign w_is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign w_is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign w_div0   = (Op2 == 32'd0);
    assign start    = (w_is_mul || w_is_div) && !r_busy;
    assign busy     = r_busy;

    // Divisor is forced to 1 on divide-by-zero so the dividers never see 0;
    // those results are discarded at commit anyway.
    assign w_divisor = w_div0 ? 32'd1 : Op2;
    assign w_smul    = $signed({{32{Op1[31]}}, Op1}) * $signed({{32{Op2[31]}}, Op2});
    assign w_umul    = {32'd0, Op1} * {32'd0, Op2};
    assign w_uq      = Op1 / w_divisor;
    assign w_ur      = Op1 % w_divisor;

    always_comb begin
        w_sq = $signed(Op1) / $signed(w_divisor);
        w_sr = $signed(Op1) % $signed(w_divisor);
        // Most-negative / -1 overflows; pin the architectural answer explicitly.
        if (Op1 == 32'h8000_0000 && Op2 == 32'hFFFF_FFFF) begin
            w_sq = 32'h8000_0000;
            w_sr = 32'd0;
        end
    end

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (MDUOp)
            OP_MULT: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
            end
            OP_DIV: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
            end
            OP_DIVU: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= 4'd0;
            r_busy <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_phi  <= 32'd0;
            r_plo  <= 32'd0;
            r_pwe  <= 1'b0;
        end else if (start) begin
            r_cnt  <= w_is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            r_busy <= 1'b1;
            r_phi  <= w_res_hi;
            r_plo  <= w_res_lo;
            r_pwe  <= !(w_is_div && w_div0);
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_busy <= 1'b0;
                r_pwe  <= 1'b0;
                if (r_pwe) begin
                    r_hi <= r_phi;
                    r_lo <= r_plo;
                end
            end
        end else begin
            if (MDUOp == OP_MTHI) r_hi <= Op1;
            if (MDUOp == OP_MTLO) r_lo <= Op1;
        end
    end

    always_comb begin
        MDUResult = 32'd0;
        if (MDUOp == OP_MFHI) MDUResult = r_hi;
        if (MDUOp == OP_MFLO) MDUResult = r_lo;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: vector table of mult/div cases plus hand-written
// sequences for divide-by-zero, issue-while-busy and reset mid-operation.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] Op1;
    logic [31:0] Op2;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] MDUResult;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[11];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op1       (Op1),
        .Op2       (Op2),
        .MDUOp     (MDUOp),
        .start     (start),
        .busy      (busy),
        .MDUResult (MDUResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pops the expected HI then LO from the scoreboard and reads them back.
    task automatic read_hilo(input string name);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        if (exp_q.size() < 2) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard underflow", name);
            return;
        end
        e_hi = exp_q.pop_front();
        e_lo = exp_q.pop_front();
        MDUOp = 4'd5;
        #1 check({name, " mfhi"}, MDUResult, e_hi);
        MDUOp = 4'd6;
        #1 check({name, " mflo"}, MDUResult, e_lo);
        MDUOp = 4'd0;
        cur_hi = e_hi;
        cur_lo = e_lo;
    endtask

    task automatic write_hilo(input logic [3:0] op, input logic [31:0] val);
        @(negedge clk);
        MDUOp = op;
        Op1   = val;
        @(negedge clk);
        MDUOp = 4'd0;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi,
                          input logic [31:0] e_lo, input int cyc);
        int n;
        @(negedge clk);
        MDUOp = op;
        Op1   = a;
        Op2   = b;
        #1 check({name, " start"}, {31'd0, start}, 32'd1);
        exp_q.push_back(e_hi);
        exp_q.push_back(e_lo);
        @(negedge clk);
        MDUOp = 4'd6;
        Op1   = $urandom;
        Op2   = $urandom;
        #1 check({name, " old lo while busy"}, MDUResult, cur_lo);
        MDUOp = 4'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({name, " busy cycles"}, 32'(n), 32'(cyc));
        read_hilo(name);
    endtask

    initial begin
        reset  = 1'b1;
        Op1    = 32'd0;
        Op2    = 32'd0;
        MDUOp  = 4'd0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        vecs[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{4'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{4'd4, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 10};
        vecs[4]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5]  = '{4'd1, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, 5};
        vecs[6]  = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[7]  = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[8]  = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[9]  = '{4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10};
        vecs[10] = '{4'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};

        repeat (2) @(negedge clk);
        #1 check("reset busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        read_hilo("reset state");
        MDUOp = 4'd9;
        #1 check("op9 start", {31'd0, start}, 32'd0);
        MDUOp = 4'd5;
        #1 check("mfhi start", {31'd0, start}, 32'd0);
        MDUOp = 4'd0;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end

        // mthi/mtlo followed by divide-by-zero, which must leave HI/LO alone.
        write_hilo(4'd7, 32'h0000_1234);
        write_hilo(4'd8, 32'h0000_5678);
        exp_q.push_back(32'h0000_1234);
        exp_q.push_back(32'h0000_5678);
        read_hilo("mthi/mtlo");
        run_op("div by zero", 4'd3, 32'd99, 32'd0, 32'h0000_1234, 32'h0000_5678, 10);
        run_op("divu by zero", 4'd4, 32'd99, 32'd0, 32'h0000_1234, 32'h0000_5678, 10);

        // Second mult and an mthi issued while the first mult is in flight are dropped.
        @(negedge clk);
        MDUOp = 4'd1;
        Op1   = 32'd7;
        Op2   = 32'd6;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd42);
        @(negedge clk);
        MDUOp = 4'd1;
        Op1   = 32'd3;
        Op2   = 32'hFFFF_FFFF;
        #1 check("issue while busy start", {31'd0, start}, 32'd0);
        @(negedge clk);
        MDUOp = 4'd7;
        Op1   = 32'hDEAD_BEEF;
        @(negedge clk);
        MDUOp = 4'd0;
        begin
            int n;
            n = 0;
            while (busy && n < 40) begin
                n++;
                @(negedge clk);
            end
            check("issue while busy tail", 32'(n), 32'd3);
        end
        read_hilo("issue while busy");

        // Asynchronous reset in the middle of a mult discards the pending result.
        @(negedge clk);
        MDUOp = 4'd1;
        Op1   = 32'd7;
        Op2   = 32'd6;
        @(negedge clk);
        MDUOp = 4'd0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("reset mid-op busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        read_hilo("reset mid-op");
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1 check("after reset busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        read_hilo("after reset");

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
